// File: rtl/sha_ctrl_pkg.sv
// Shared SHA-2 control definitions: round-counter state encoding and round counts.
package sha_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rcnt_state_t;

  localparam int SHA512_ROUNDS = 80;
  localparam int SHA256_ROUNDS = 64;

  localparam int RCNT_WIDTH_DEFAULT = 7;   // enough for 0..79
  localparam int RCNT_WIDTH_SHA256  = 6;   // enough for 0..63

endpackage

// File: rtl/sha_round_counter_if.sv
// Control/status bundle between the SHA core controller and the round counter.
interface sha_round_counter_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic             stall;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             last;
  logic             done;

  modport master (output start, stall, abort, input count, busy, last, done);
  modport slave  (input start, stall, abort, output count, busy, last, done);
endinterface

// File: rtl/sha_round_counter.sv
// Round/step counter with IDLE/RUN/DONE control for the SHA-2 round datapath.
// Define SHA_RCNT_DONE_PULSE_EN to make done a one-cycle pulse instead of a level.
module sha_round_counter
  import sha_ctrl_pkg::*;
#(
  parameter int WIDTH       = RCNT_WIDTH_DEFAULT,
  parameter int MAX_COUNT   = SHA512_ROUNDS - 1,
  parameter int START_VALUE = 0
) (
  input  logic                clk,
  input  logic                reset,
  sha_round_counter_if.slave  bus
);

  if ((MAX_COUNT >> WIDTH) != 0 || START_VALUE > MAX_COUNT || START_VALUE < 0) begin : g_param_chk
    $error("sha_round_counter: need START_VALUE <= MAX_COUNT < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] START_C = WIDTH'(START_VALUE);

  rcnt_state_t      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q,  done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= START_C;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // abort beats start beats stall beats increment
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    if (bus.abort) begin
      state_d = IDLE;
      count_d = START_C;
      done_d  = 1'b0;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = START_C;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = START_C;
          done_d  = 1'b0;
        end
        RUN: begin
          if (!bus.stall) begin
            if (count_q == MAX_C) begin
              state_d = DONE;
              count_d = START_C;
              done_d  = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        DONE: begin
`ifdef SHA_RCNT_DONE_PULSE_EN
          done_d = 1'b0;   // state lingers in DONE, the flag does not
`else
          done_d = 1'b1;
`endif
        end
        default: begin
          state_d = IDLE;
          count_d = START_C;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.last  = bus.busy & (count_q == MAX_C);
  assign bus.done  = done_q & ~bus.start;

endmodule

// File: tb/tb_sha_round_counter.sv
// Self-checking bench: three counter configurations driven in parallel against a round-level model.
module tb_sha_round_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stall = 1'b0, abort = 1'b0;
  int   checks = 0, errors = 0;
  bit   checking = 1'b0;

  always #5 clk = ~clk;

  sha_round_counter_if #(.WIDTH(7)) b0 ();
  sha_round_counter_if #(.WIDTH(6)) b1 ();
  sha_round_counter_if #(.WIDTH(4)) b2 ();

  assign b0.start = start; assign b0.stall = stall; assign b0.abort = abort;
  assign b1.start = start; assign b1.stall = stall; assign b1.abort = abort;
  assign b2.start = start; assign b2.stall = stall; assign b2.abort = abort;

  sha_round_counter #(.WIDTH(7), .MAX_COUNT(79), .START_VALUE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  sha_round_counter #(.WIDTH(6), .MAX_COUNT(63), .START_VALUE(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  sha_round_counter #(.WIDTH(4), .MAX_COUNT(5),  .START_VALUE(5)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  // Model: mode 0=idle 1=running 2=finished; age counts edges spent finished.
  int mx [3] = '{79, 63, 5};
  int sv [3] = '{0, 0, 5};
  int mmode [3];
  int mcnt  [3];
  int mage  [3];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset)                      begin mmode[i] = 0; mcnt[i] = sv[i]; mage[i] = 0; end
      else if (abort)                 begin mmode[i] = 0; mcnt[i] = sv[i]; end
      else if (start)                 begin mmode[i] = 1; mcnt[i] = sv[i]; end
      else if (mmode[i] == 1 && !stall) begin
        if (mcnt[i] == mx[i])         begin mmode[i] = 2; mcnt[i] = sv[i]; mage[i] = 0; end
        else                          mcnt[i] = mcnt[i] + 1;
      end else if (mmode[i] == 2)     mage[i] = mage[i] + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int i, input logic [31:0] c, input logic b, input logic l, input logic d);
    logic eb, ed;
    eb = (mmode[i] == 1);
`ifdef SHA_RCNT_DONE_PULSE_EN
    ed = (mmode[i] == 2) && (mage[i] == 0) && !start;
`else
    ed = (mmode[i] == 2) && !start;
`endif
    chk($sformatf("model.count[%0d]", i), c, mcnt[i]);
    chk($sformatf("model.busy[%0d]", i), {31'd0, b}, {31'd0, eb});
    chk($sformatf("model.last[%0d]", i), {31'd0, l}, {31'd0, eb && (mcnt[i] == mx[i])});
    chk($sformatf("model.done[%0d]", i), {31'd0, d}, {31'd0, ed});
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp_one(0, {25'd0, b0.count}, b0.busy, b0.last, b0.done);
      cmp_one(1, {26'd0, b1.count}, b1.busy, b1.last, b1.done);
      cmp_one(2, {28'd0, b2.count}, b2.busy, b2.last, b2.done);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 checking = 1'b1;
    tick(2);
    chk("rst.count", {25'd0, b0.count}, 0);
    chk("rst.busy", {31'd0, b0.busy}, 0);
    chk("rst.done", {31'd0, b0.done}, 0);
    chk("rst.count_deg", {28'd0, b2.count}, 5);
    reset = 1'b0;
    tick(2);

    // full run, no stall
    pulse_start();
    chk("run.first", {25'd0, b0.count}, 0);
    chk("run.busy", {31'd0, b0.busy}, 1);
    chk("deg.last", {31'd0, b2.last}, 1);
    chk("deg.count", {28'd0, b2.count}, 5);
    tick(1);
    chk("deg.done", {31'd0, b2.done}, 1);
    chk("deg.busy", {31'd0, b2.busy}, 0);
    tick(62);
    chk("w6.count63", {26'd0, b1.count}, 63);
    chk("w6.last", {31'd0, b1.last}, 1);
    chk("run.last_early", {31'd0, b0.last}, 0);
    tick(1);
    chk("w6.wrap", {26'd0, b1.count}, 0);
    chk("w6.done", {31'd0, b1.done}, 1);
    tick(15);
    chk("run.count79", {25'd0, b0.count}, 79);
    chk("run.last79", {31'd0, b0.last}, 1);
    tick(1);
    chk("run.done", {31'd0, b0.done}, 1);
    chk("run.busy_off", {31'd0, b0.busy}, 0);
    chk("run.wrap", {25'd0, b0.count}, 0);
    tick(1);
`ifdef SHA_RCNT_DONE_PULSE_EN
    chk("done.pulse_low", {31'd0, b0.done}, 0);
`else
    chk("done.level_held", {31'd0, b0.done}, 1);
`endif
    start = 1'b1; #1;
    chk("done.masked", {31'd0, b0.done}, 0);

    // stall at 10 for 3 cycles
    tick(1);
    start = 1'b0;
    tick(10);
    chk("stall.at10", {25'd0, b0.count}, 10);
    stall = 1'b1;
    tick(3);
    stall = 1'b0;
    chk("stall.held", {25'd0, b0.count}, 10);
    tick(1);
    chk("stall.resume", {25'd0, b0.count}, 11);
    tick(68);
    chk("stall.count79", {25'd0, b0.count}, 79);
    chk("stall.busy", {31'd0, b0.busy}, 1);
    tick(1);
    chk("stall.done84", {31'd0, b0.done}, 1);

    // abort at 40, then a fresh full run with stall on the last round
    pulse_start();
    tick(40);
    chk("abort.at40", {25'd0, b0.count}, 40);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort.count", {25'd0, b0.count}, 0);
    chk("abort.busy", {31'd0, b0.busy}, 0);
    chk("abort.done", {31'd0, b0.done}, 0);
    pulse_start();
    tick(79);
    stall = 1'b1;
    tick(2);
    stall = 1'b0;
    chk("laststall.count", {25'd0, b0.count}, 79);
    chk("laststall.last", {31'd0, b0.last}, 1);
    tick(1);
    chk("laststall.done", {31'd0, b0.done}, 1);

    // restart at 50 with simultaneous stall
    pulse_start();
    tick(50);
    chk("restart.at50", {25'd0, b0.count}, 50);
    start = 1'b1; stall = 1'b1;
    tick(1);
    start = 1'b0; stall = 1'b0;
    chk("restart.zero", {25'd0, b0.count}, 0);
    tick(79);
    chk("restart.count79", {25'd0, b0.count}, 79);
    tick(1);
    chk("restart.done", {31'd0, b0.done}, 1);

    // async reset mid-cycle
    pulse_start();
    tick(30);
    chk("areset.at30", {25'd0, b0.count}, 30);
    #2 reset = 1'b1;
    #1;
    chk("areset.count", {25'd0, b0.count}, 0);
    chk("areset.busy", {31'd0, b0.busy}, 0);
    chk("areset.last", {31'd0, b0.last}, 0);
    chk("areset.done", {31'd0, b0.done}, 0);
    chk("areset.w6count", {26'd0, b1.count}, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("areset.idle", {31'd0, b0.busy}, 0);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
